// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and filter the pins, deserialise frames, buffer scancodes.
// Latency: last PS2_CLK pin fall to SCANCODE valid is 3 + FILTER_LEN CLK cycles.
// Backpressure: none toward the keyboard; a byte arriving while the FIFO is full is dropped and flagged.

// Generic FIFO with first-word-fall-through read.
// Latency: pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens on the same edge.
module ps2_kbd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full,
  output logic         push_ok
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop_vld & ~empty;
  // A pop on the same edge frees the slot the push needs, so a full FIFO still accepts.
  assign push_ok = push_vld & (~full | pop_ok);
  assign pop_dat = mem_q[rd_ptr_q];

  // Next-state for storage, pointers (wrap naturally at power-of-two depth) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// Pin conditioner: 2-flop synchroniser followed by a consecutive-sample glitch filter.
// Latency: filtered level follows a clean pin change after 2 + FILTER_LEN cycles.
// Backpressure: none.
module ps2_kbd_pin_filt #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic filt
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign filt = filt_q;

  // Count consecutive samples disagreeing with the filtered level; flip once enough agree.
  always_comb begin
    s1_d   = pin;
    s2_d   = s1_q;
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Idle-high PS/2 lines: everything resets to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// Top: PS/2 frame receiver with scancode FIFO, interrupt pulse and sticky error flags.
// Latency: scancode and INTR appear 3 + FILTER_LEN cycles after the stop-bit clock fall.
// Backpressure: FULL without POP drops the byte and raises OVERRUN.
module ps2_kbd_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int DEPTH       = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       POP,
  input  logic       CLR_ERR,
  output logic [7:0] SCANCODE,
  output logic       EMPTY,
  output logic       FULL,
  output logic       INTR,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          clk_prev_q, clk_prev_d;
  logic          intr_q, intr_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic          clk_filt, dat_filt, fe;
  logic          push_vld, push_ok, par_evt, frame_evt, ovr_evt;
  logic [7:0]    fifo_dat;
  logic          fifo_empty, fifo_full;

  ps2_kbd_pin_filt #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(CLK), .rst_n(RST_N), .pin(PS2_CLK), .filt(clk_filt)
  );

  ps2_kbd_pin_filt #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(CLK), .rst_n(RST_N), .pin(PS2_DATA), .filt(dat_filt)
  );

  ps2_kbd_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK), .rst_n(RST_N),
    .push_vld(push_vld), .push_dat(shift_q),
    .pop_vld(POP), .pop_dat(fifo_dat),
    .empty(fifo_empty), .full(fifo_full), .push_ok(push_ok)
  );

  assign fe       = clk_prev_q & ~clk_filt;
  assign ovr_evt  = push_vld & ~push_ok;
  assign SCANCODE = fifo_empty ? 8'h00 : fifo_dat;
  assign EMPTY    = fifo_empty;
  assign FULL     = fifo_full;
  assign INTR       = intr_q;
  assign PARITY_ERR = parity_err_q;
  assign FRAME_ERR  = frame_err_q;
  assign OVERRUN    = overrun_q;

  // Frame FSM: advance on each filtered clock fall; abort a stalled partial frame.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = '0;
    push_vld  = 1'b0;
    par_evt   = 1'b0;
    frame_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fe && !dat_filt) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fe) begin
          shift_d   = {dat_filt, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fe) begin
          par_d   = dat_filt;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fe) begin
          state_d = IDLE;
          if (!dat_filt) begin
            frame_evt = 1'b1;
          end else if (^{shift_q, par_q}) begin
            push_vld = 1'b1;
          end else begin
            par_evt = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The counter only runs mid-frame and restarts on every clock fall.
    if (state_q != IDLE && !fe) begin
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d   = IDLE;
        frame_evt = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Edge-detect history, interrupt pulse and sticky flags (a new event beats CLR_ERR).
  always_comb begin
    clk_prev_d   = clk_filt;
    intr_d       = push_ok;
    parity_err_d = (parity_err_q & ~CLR_ERR) | par_evt;
    frame_err_d  = (frame_err_q & ~CLR_ERR) | frame_evt;
    overrun_d    = (overrun_q & ~CLR_ERR) | ovr_evt;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      clk_prev_q   <= 1'b1;
      intr_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      clk_prev_q   <= clk_prev_d;
      intr_q       <= intr_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx: directed PS/2 frames, scoreboard of expected scancodes.
// A monitor compares SCANCODE against the scoreboard on every accepted POP and counts INTR pulses.
// PS/2 clock half period is scaled down to 40 CLK cycles so that the bench stays short.
module tb_ps2_kbd_rx;
  localparam int HALF = 40;

  logic       CLK      = 1'b0;
  logic       RST_N    = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic       POP      = 1'b0;
  logic       CLR_ERR  = 1'b0;
  logic [7:0] SCANCODE;
  logic       EMPTY, FULL, INTR, PARITY_ERR, FRAME_ERR, OVERRUN;

  int         tests     = 0;
  int         fails     = 0;
  int         intr_seen = 0;
  int         exp_intr  = 0;
  logic [7:0] exp_q[$];

  ps2_kbd_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(1000), .DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .POP(POP), .CLR_ERR(CLR_ERR), .SCANCODE(SCANCODE), .EMPTY(EMPTY),
    .FULL(FULL), .INTR(INTR), .PARITY_ERR(PARITY_ERR),
    .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One PS/2 bit: data set while clock is high, then a low half and a high half.
  // With pop_sync the POP strobe lands on the edge where the stop bit's push happens
  // (2 synchroniser + 8 filter edges, then one edge to act on the detected fall).
  task automatic ps2_bit(input logic b, input bit pop_sync);
    @(negedge CLK);
    PS2_DATA = b;
    idle(HALF);
    PS2_CLK = 1'b0;
    if (pop_sync) begin
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      POP = 1'b1;
      @(negedge CLK);
      POP = 1'b0;
      idle(HALF - 11);
    end else begin
      idle(HALF);
    end
    PS2_CLK = 1'b1;
  endtask

  // Send the first nbits of a frame: start, 8 data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits, input bit pop_last);
    logic [10:0] fr;
    fr = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_bit(fr[i], pop_last && (i == 10));
    end
  endtask

  // Correct odd-parity frame; record it in the scoreboard when it should be accepted.
  task automatic send_byte(input logic [7:0] d, input bit expect_push);
    if (expect_push) begin
      exp_q.push_back(d);
      exp_intr++;
    end
    send_frame(d, ~^d, 1'b1, 11, 1'b0);
  endtask

  task automatic do_pop();
    @(negedge CLK);
    POP = 1'b1;
    @(negedge CLK);
    POP = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge CLK);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
  endtask

  // Monitor: count INTR pulses and check each accepted pop against the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (INTR === 1'b1) intr_seen++;
      if (POP === 1'b1 && EMPTY === 1'b0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_data: popped 0x%02h with no scancode expected", SCANCODE);
        end else begin
          check("pop_data", 32'(SCANCODE), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, got %0d tests, expected completion", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    RST_N = 1'b1;
    idle(2);
    check("reset_empty", 32'(EMPTY), 32'd1);
    check("reset_full", 32'(FULL), 32'd0);
    check("reset_scancode", 32'(SCANCODE), 32'h00);
    check("reset_intr", 32'(INTR), 32'd0);
    check("reset_flags", 32'({PARITY_ERR, FRAME_ERR, OVERRUN}), 32'd0);

    // Make code 'A' (0x1C, parity 0)
    send_byte(8'h1C, 1'b1);
    idle(20);
    check("a_scancode", 32'(SCANCODE), 32'h1C);
    check("a_empty", 32'(EMPTY), 32'd0);
    check("a_flags", 32'({PARITY_ERR, FRAME_ERR, OVERRUN}), 32'd0);
    check("a_intr", 32'(intr_seen), 32'd1);
    do_pop();
    check("a_pop_empty", 32'(EMPTY), 32'd1);
    check("a_pop_scancode", 32'(SCANCODE), 32'h00);

    // Parity error: 0xF0 needs parity 1, send 0
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    idle(20);
    check("par_err", 32'(PARITY_ERR), 32'd1);
    check("par_empty", 32'(EMPTY), 32'd1);
    check("par_intr", 32'(intr_seen), 32'(exp_intr));
    pulse_clr();
    check("par_clr", 32'(PARITY_ERR), 32'd0);
    send_byte(8'hF0, 1'b1);
    idle(20);
    check("par_good_scancode", 32'(SCANCODE), 32'hF0);
    do_pop();

    // Overrun: five bytes into a four-entry FIFO
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(20);
    check("ovr_full", 32'(FULL), 32'd1);
    check("ovr_flag", 32'(OVERRUN), 32'd1);
    check("ovr_intr", 32'(intr_seen), 32'd6);
    check("ovr_head", 32'(SCANCODE), 32'h11);
    repeat (4) do_pop();
    check("ovr_drain_empty", 32'(EMPTY), 32'd1);
    check("ovr_drain_full", 32'(FULL), 32'd0);
    pulse_clr();
    check("ovr_clr", 32'(OVERRUN), 32'd0);

    // Push coinciding with POP while full
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    send_byte(8'h63, 1'b1);
    send_byte(8'h64, 1'b1);
    idle(20);
    check("coin_full_before", 32'(FULL), 32'd1);
    exp_q.push_back(8'h65);
    exp_intr++;
    send_frame(8'h65, ~^8'h65, 1'b1, 11, 1'b1);
    idle(20);
    check("coin_full", 32'(FULL), 32'd1);
    check("coin_overrun", 32'(OVERRUN), 32'd0);
    check("coin_intr", 32'(intr_seen), 32'(exp_intr));
    check("coin_head", 32'(SCANCODE), 32'h62);
    repeat (4) do_pop();
    check("coin_empty", 32'(EMPTY), 32'd1);

    // Timeout: start + 4 data bits, then clock held high
    send_frame(8'h29, ~^8'h29, 1'b1, 5, 1'b0);
    idle(760);
    check("to_early", 32'(FRAME_ERR), 32'd0);
    idle(400);
    check("to_flag", 32'(FRAME_ERR), 32'd1);
    check("to_empty", 32'(EMPTY), 32'd1);
    check("to_intr", 32'(intr_seen), 32'(exp_intr));
    send_byte(8'h29, 1'b1);
    idle(20);
    check("to_next", 32'(SCANCODE), 32'h29);
    check("to_sticky", 32'(FRAME_ERR), 32'd1);
    do_pop();
    pulse_clr();
    check("to_clr", 32'(FRAME_ERR), 32'd0);

    // Glitch: 3-cycle clock low with data low must not start a frame (would time out)
    @(negedge CLK);
    PS2_DATA = 1'b0;
    idle(20);
    PS2_CLK = 1'b0;
    idle(3);
    PS2_CLK = 1'b1;
    idle(20);
    PS2_DATA = 1'b1;
    idle(1200);
    check("glitch_flags", 32'({PARITY_ERR, FRAME_ERR, OVERRUN}), 32'd0);
    check("glitch_empty", 32'(EMPTY), 32'd1);
    check("glitch_intr", 32'(intr_seen), 32'(exp_intr));

    // Reset mid-frame with two bytes buffered and a flag set
    send_frame(8'h35, 1'b0, 1'b1, 11, 1'b0);
    send_byte(8'h4A, 1'b1);
    send_byte(8'h5B, 1'b1);
    idle(20);
    check("rst_pre_buffered", 32'(SCANCODE), 32'h4A);
    check("rst_pre_perr", 32'(PARITY_ERR), 32'd1);
    send_frame(8'h77, ~^8'h77, 1'b1, 6, 1'b0);
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    exp_q.delete();
    #1;
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_scancode", 32'(SCANCODE), 32'h00);
    check("rst_flags", 32'({PARITY_ERR, FRAME_ERR, OVERRUN}), 32'd0);
    idle(20);
    send_byte(8'h1C, 1'b1);
    idle(20);
    check("rst_next", 32'(SCANCODE), 32'h1C);
    check("rst_next_flags", 32'({PARITY_ERR, FRAME_ERR, OVERRUN}), 32'd0);
    do_pop();
    check("rst_final_empty", 32'(EMPTY), 32'd1);

    idle(5);
    check("final_intr", 32'(intr_seen), 32'(exp_intr));
    check("final_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Memory-mapped keyboard input peripheral that feeds the MCU IOBUS read mux at address 0x11000100 (KEYBOARD_AD) and drives CPU_INTR.
- Deserialises PS/2 device-to-host frames and buffers scancodes in a small first-word-fall-through FIFO.
- Reports parity, framing and overrun errors to the CPU.
- Runs on the 50 MHz CPU clock (sclk domain).

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before PS2_CLK/PS2_DATA filtered level changes
TIMEOUT_CYC, 100000, CLK cycles without a filtered PS2_CLK falling edge before a partial frame is aborted (2 ms at 50 MHz)
DEPTH, 4, FIFO entries, power of two, >=2

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  synchronous active-low reset
PS2_CLK  input  1  asynchronous keyboard clock pin
PS2_DATA  input  1  asynchronous keyboard data pin
POP  input  1  one-cycle strobe from CPU read of KEYBOARD_AD; removes head entry
CLR_ERR  input  1  one-cycle strobe; clears sticky error flags
SCANCODE  output  8  FIFO head (FWFT); 0x00 when empty
EMPTY  output  1  FIFO empty
FULL  output  1  FIFO full
INTR  output  1  one-cycle pulse on every successful FIFO push
PARITY_ERR  output  1  sticky, bad odd parity seen
FRAME_ERR  output  1  sticky, bad start/stop bit or timeout
OVERRUN  output  1  sticky, valid byte dropped because FIFO full

Behaviour:
- Reset, sampled on a CLK edge with RST_N=0, applies regardless of state:
  - FIFO cleared. EMPTY=1, FULL=0, SCANCODE=0x00.
  - INTR=0; all error flags 0.
  - FSM returns to IDLE; bit counter and timeout counter cleared.
  - Filtered PS2_CLK/PS2_DATA set to 1.
- Input conditioning:
  - Each pin goes through a 2-flop synchroniser, then a counter filter.
  - The filtered level changes only after FILTER_LEN equal consecutive samples.
  - A falling edge of filtered PS2_CLK is a single-cycle internal event "fe".
- FSM states: IDLE, DATA, PARITY, STOP. Each state advances only on fe, sampling filtered PS2_DATA.
  - IDLE: data=0 -> DATA with bit count 0. Data=1 -> stay in IDLE, no flag.
  - DATA: shift bit into shift register, LSB first. After the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: always returns to IDLE, with the outcome chosen as follows:
    - Stop=1 and odd parity holds over (8 data + parity): push byte.
    - Stop=0: set FRAME_ERR, discard byte.
    - Parity wrong (stop=1): set PARITY_ERR, discard byte.
- Timeout:
  - In any state other than IDLE, the counter increments each CLK and resets on fe.
  - On reaching TIMEOUT_CYC: FSM returns to IDLE, FRAME_ERR=1, partial byte discarded.
- FIFO:
  - Push occurs on the CLK edge after the STOP-state fe. INTR=1 for exactly that cycle.
  - SCANCODE/EMPTY/FULL update on the same edge as the push.
  - Push while FULL with no POP: byte dropped, OVERRUN=1, INTR stays 0.
  - Push and POP in the same cycle: both take effect, including when FULL (count unchanged, no overrun).
  - POP while EMPTY: ignored, no state change.
  - Pointers wrap modulo DEPTH.
- Errors: sticky until CLR_ERR. If CLR_ERR coincides with a new error event, the flag ends set.
- Latency: last PS2_CLK falling pin edge to SCANCODE valid is at most 2 + FILTER_LEN + 2 CLK cycles.

Test Plan:
- Make code 'A':
  - Stimulus: frame 0x1C; bits start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1; PS2_CLK period 80 us.
  - Required: one INTR pulse, SCANCODE=0x1C, EMPTY=0, no error flags. POP -> EMPTY=1, SCANCODE=0x00.
- Parity error:
  - Stimulus: 0xF0 sent with parity 0 (correct value is 1).
  - Required: PARITY_ERR=1, EMPTY stays 1, no INTR.
  - Then CLR_ERR -> PARITY_ERR=0. Next frame 0xF0 with parity 1 -> SCANCODE=0xF0.
- Overrun with DEPTH=4:
  - Stimulus: send 0x11, 0x22, 0x33, 0x44, 0x55 with no POP.
  - Required: FULL=1, OVERRUN=1, exactly 4 INTR pulses.
  - Pops return 0x11, 0x22, 0x33, 0x44, then EMPTY=1.
  - Push on the same cycle as POP while FULL: accepted, OVERRUN unchanged.
- Timeout:
  - Stimulus: start bit plus 4 data bits, then PS2_CLK held high with TIMEOUT_CYC=1000.
  - Required: FRAME_ERR=1 after 1000 cycles. A following full frame 0x29 is received correctly.
- Glitch rejection: a 3-cycle low pulse on PS2_CLK while idle, with FILTER_LEN=8, produces no FSM transition, no flags and no INTR.
- Reset mid-frame:
  - Stimulus: RST_N=0 for one cycle after the 5th data bit of a frame, with 2 bytes buffered.
  - Required: EMPTY=1, flags 0, FSM in IDLE. The next complete frame 0x1C is received correctly.
